// File: rtl/tia_horizontal_decode.sv
// TIA horizontal sync/blank/burst/centre decode from the 6-bit horizontal LFSR count.
// Build option: define TIA_HMOVE_EN to include the HMOVE late-blank latch.
module tia_horizontal_decode (
    input  logic       clk,
    input  logic       resl,
    input  logic       hphi_en,
    input  logic [5:0] hcount,
    input  logic       shb,
    input  logic       wsync_strobe,
    input  logic       hmove_strobe,
    output logic       hsync,
    output logic       hblank,
    output logic       cburst,
    output logic       cnt,
    output logic       rdy,
    output logic       hmove_late
);

    localparam logic [5:0] P_SHS = 6'b111100;
    localparam logic [5:0] P_RHS = 6'b110111;
    localparam logic [5:0] P_RCB = 6'b001111;
    localparam logic [5:0] P_RHB = 6'b011100;
    localparam logic [5:0] P_CNT = 6'b101100;

    logic w_shs;
    logic w_rhs;
    logic w_rcb;
    logic w_rhb;
    logic w_cnt;
    logic w_shb;
    logic w_hblank_clr;

    logic r_hsync;
    logic r_hblank;
    logic r_cburst;
    logic r_cnt;
    logic r_rdy;

    assign w_shs = hphi_en && (hcount == P_SHS);
    assign w_rhs = hphi_en && (hcount == P_RHS);
    assign w_rcb = hphi_en && (hcount == P_RCB);
    assign w_rhb = hphi_en && (hcount == P_RHB);
    assign w_cnt = hphi_en && (hcount == P_CNT);
    assign w_shb = hphi_en && shb;

`ifdef TIA_HMOVE_EN
    localparam logic [5:0] P_LRHB = 6'b010111;

    logic w_lrhb;
    logic w_late_eff;
    logic r_hmove_late;

    assign w_lrhb = hphi_en && (hcount == P_LRHB);
    // A strobe landing on the RHB clock already counts as a late line.
    assign w_late_eff   = r_hmove_late | hmove_strobe;
    assign w_hblank_clr = (w_rhb && !w_late_eff) || (w_lrhb && w_late_eff);

    always_ff @(posedge clk) begin
        if (!resl) begin
            r_hmove_late <= 1'b0;
        end else if (hmove_strobe) begin
            r_hmove_late <= 1'b1;
        end else if (w_lrhb) begin
            r_hmove_late <= 1'b0;
        end
    end

    assign hmove_late = r_hmove_late;
`else
    logic w_unused_hmove;

    assign w_unused_hmove = hmove_strobe;
    assign w_hblank_clr   = w_rhb;
    assign hmove_late     = 1'b0;
`endif

    // SHB set actions are ordered after the decode clears so SHB wins on overlap.
    always_ff @(posedge clk) begin
        if (!resl) begin
            r_hsync  <= 1'b0;
            r_hblank <= 1'b1;
            r_cburst <= 1'b0;
            r_cnt    <= 1'b0;
            r_rdy    <= 1'b1;
        end else begin
            if (w_shs) begin
                r_hsync <= 1'b1;
            end else if (w_rhs) begin
                r_hsync <= 1'b0;
            end

            if (w_rhs) begin
                r_cburst <= 1'b1;
            end else if (w_rcb) begin
                r_cburst <= 1'b0;
            end

            if (w_shb) begin
                r_hblank <= 1'b1;
            end else if (w_hblank_clr) begin
                r_hblank <= 1'b0;
            end

            r_cnt <= w_cnt;

            if (wsync_strobe) begin
                r_rdy <= 1'b0;
            end else if (w_shb) begin
                r_rdy <= 1'b1;
            end
        end
    end

    assign hsync  = r_hsync;
    assign hblank = r_hblank;
    assign cburst = r_cburst;
    assign cnt    = r_cnt;
    assign rdy    = r_rdy;

endmodule

// File: tb/tb_tia_horizontal_decode.sv
// Self-checking bench for tia_horizontal_decode: directed line scenarios plus randomized lines
// checked every clock against a rule-level model of the decode (honours TIA_HMOVE_EN).
`timescale 1ns/1ps
module tb_tia_horizontal_decode;

    logic       clk = 1'b0;
    logic       resl = 1'b0;
    logic       hphi_en = 1'b0;
    logic [5:0] hcount = '0;
    logic       shb = 1'b0;
    logic       wsync_strobe = 1'b0;
    logic       hmove_strobe = 1'b0;
    logic       hsync, hblank, cburst, cnt, rdy, hmove_late;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    bit          en_cmp = 1'b0;
    int          cnt_seen = 0;
    bit          rnd_neutral = 1'b0;
    int          extra_shb_step = -1;

    always #5 clk = ~clk;

    tia_horizontal_decode dut (
        .clk          (clk),
        .resl         (resl),
        .hphi_en      (hphi_en),
        .hcount       (hcount),
        .shb          (shb),
        .wsync_strobe (wsync_strobe),
        .hmove_strobe (hmove_strobe),
        .hsync        (hsync),
        .hblank       (hblank),
        .cburst       (cburst),
        .cnt          (cnt),
        .rdy          (rdy),
        .hmove_late   (hmove_late)
    );

    typedef struct packed {
        bit hsync;
        bit hblank;
        bit cburst;
        bit cnt;
        bit rdy;
        bit late;
    } st_t;

    localparam st_t RST = 6'b010010;
    st_t m;

    // Reference: apply each named line event's effect, SHB sets last, WSYNC clear overriding.
    function automatic st_t model_next(st_t s, bit r, bit ph, bit [5:0] c, bit sh, bit ws, bit hm);
        st_t n;
        bit  late_eff;
        if (!r) return RST;
        n = s;
        n.cnt = 1'b0;
`ifdef TIA_HMOVE_EN
        late_eff = s.late || hm;
`else
        late_eff = 1'b0;
`endif
        if (ph) begin
            case (c)
                6'b111100: n.hsync = 1'b1;
                6'b110111: begin n.hsync = 1'b0; n.cburst = 1'b1; end
                6'b001111: n.cburst = 1'b0;
                6'b011100: if (!late_eff) n.hblank = 1'b0;
`ifdef TIA_HMOVE_EN
                6'b010111: begin if (late_eff) n.hblank = 1'b0; n.late = 1'b0; end
`endif
                6'b101100: n.cnt = 1'b1;
                default: ;
            endcase
            if (sh) begin
                n.hblank = 1'b1;
                n.rdy    = 1'b1;
            end
        end
`ifdef TIA_HMOVE_EN
        if (hm) n.late = 1'b1;
`endif
        if (ws) n.rdy = 1'b0;
        return n;
    endfunction

    always @(posedge clk) m <= model_next(m, resl, hphi_en, hcount, shb, wsync_strobe, hmove_strobe);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (en_cmp) begin
            chk("hsync",      32'(hsync),      32'(m.hsync));
            chk("hblank",     32'(hblank),     32'(m.hblank));
            chk("cburst",     32'(cburst),     32'(m.cburst));
            chk("cnt",        32'(cnt),        32'(m.cnt));
            chk("rdy",        32'(rdy),        32'(m.rdy));
            chk("hmove_late", 32'(hmove_late), 32'(m.late));
            if (cnt === 1'b1) cnt_seen++;
        end
    end

    // Vector order: hsync hblank cburst cnt rdy hmove_late; checks DUT and model against a literal.
    task automatic expect6(input string name, input logic [5:0] exp);
        chk(name, 32'({hsync, hblank, cburst, cnt, rdy, hmove_late}), 32'(exp));
        chk({name, "_model"}, 32'(m), 32'(exp));
    endtask

    function automatic logic [5:0] line_count(int s);
        logic [5:0] v;
        case (s)
            4:  return 6'b111100;
            8:  return 6'b110111;
            12: return 6'b001111;
            16: return 6'b011100;
            18: return 6'b010111;
            36: return 6'b101100;
            56: return 6'b010100;
            default: begin
                if (!rnd_neutral) return 6'b000000;
                do begin
                    v = 6'($urandom_range(63));
                end while (v == 6'b111100 || v == 6'b110111 || v == 6'b001111 ||
                           v == 6'b011100 || v == 6'b010111 || v == 6'b101100);
                return v;
            end
        endcase
    endfunction

    task automatic run_range(input int first, input int last, input int ws_step, input int ws_clk,
                             input int hm_step, input int hm_clk);
        for (int s = first; s <= last; s++) begin
            hcount = line_count(s);
            for (int k = 0; k < 4; k++) begin
                hphi_en      = (k == 0);
                shb          = (s == 0) || (s == extra_shb_step);
                wsync_strobe = (s == ws_step) && (k == ws_clk);
                hmove_strobe = (s == hm_step) && (k == hm_clk);
                @(posedge clk); #1;
            end
        end
        hphi_en = 1'b0; shb = 1'b0; wsync_strobe = 1'b0; hmove_strobe = 1'b0;
    endtask

    task automatic plain(input int first, input int last);
        run_range(first, last, -1, -1, -1, -1);
    endtask

    task automatic pulse_reset();
        resl = 1'b0;
        @(posedge clk); #1;
        resl = 1'b1;
    endtask

    initial begin
        int ws_s, ws_c, hm_s, hm_c, rst_s;
        #1;
        resl = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        expect6("reset", 6'b010010);
        en_cmp = 1'b1;
        resl = 1'b1;

        // Nominal line
        plain(0, 3);   expect6("pre_shs", 6'b010010);
        plain(4, 4);   expect6("shs",     6'b110010);
        plain(5, 8);   expect6("rhs",     6'b011010);
        plain(9, 12);  expect6("rcb",     6'b010010);
        plain(13, 15); expect6("pre_rhb", 6'b010010);
        plain(16, 16); expect6("rhb",     6'b000010);
        cnt_seen = 0;
        plain(17, 35); chk("cnt_before_36", 32'(cnt_seen), 32'd0);
        plain(36, 56); chk("cnt_pulses", 32'(cnt_seen), 32'd1);

        // WSYNC mid-line
        plain(0, 19);
        run_range(20, 20, 20, 1, -1, -1); chk("wsync_rdy_low", 32'(rdy), 32'd0);
        plain(21, 56); chk("wsync_rdy_held", 32'(rdy), 32'd0);
        plain(0, 0);   chk("wsync_rdy_shb", 32'(rdy), 32'd1);
        plain(1, 56);

        // WSYNC on the SHB clock waits a whole line
        run_range(0, 0, 0, 0, -1, -1); chk("wsync_shb_low", 32'(rdy), 32'd0);
        plain(1, 56); chk("wsync_shb_line", 32'(rdy), 32'd0);
        plain(0, 0);  chk("wsync_shb_rise", 32'(rdy), 32'd1);
        plain(1, 56);

`ifdef TIA_HMOVE_EN
        run_range(0, 2, -1, -1, 2, 2);
        plain(3, 16);  expect6("hm_rhb_ignored", 6'b010011);
        plain(17, 18); expect6("hm_lrhb",        6'b000010);
        plain(19, 56);
        plain(0, 16);  expect6("hm_next_line",   6'b000010);
        plain(17, 56);
        plain(0, 29);
        run_range(30, 30, -1, -1, 30, 3); expect6("hm_late_strobe", 6'b000011);
        plain(31, 56);
        plain(0, 16);  expect6("hm_carry_rhb",  6'b010011);
        plain(17, 18); expect6("hm_carry_lrhb", 6'b000010);
        plain(19, 56);
`else
        run_range(0, 2, -1, -1, 2, 2);
        plain(3, 16);  expect6("nohm_rhb", 6'b000010);
        plain(17, 56);
`endif

        // Mid-line reset, error count, resynchronisation
        plain(0, 5); expect6("pre_midreset", 6'b110010);
        pulse_reset(); expect6("midreset", 6'b010010);
        plain(6, 56);
        plain(0, 0); expect6("err_start", 6'b010010);
        hcount = 6'b111111;
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 4; k++) begin
                hphi_en = (k == 0);
                @(posedge clk); #1;
            end
        end
        hphi_en = 1'b0;
        expect6("err_count_hold", 6'b010010);
        plain(1, 4); expect6("resync_shs", 6'b110010);
        plain(5, 56);

        // Randomized lines
        rnd_neutral = 1'b1;
        for (int line = 0; line < 40; line++) begin
            ws_s = ($urandom_range(1) == 0) ? int'($urandom_range(56)) : -1;
            ws_c = int'($urandom_range(3));
            hm_s = ($urandom_range(1) == 0) ? int'($urandom_range(56)) : -1;
            hm_c = int'($urandom_range(3));
            rst_s = ($urandom_range(7) == 0) ? int'($urandom_range(1, 56)) : -1;
            case ($urandom_range(7))
                0: extra_shb_step = 4;
                1: extra_shb_step = 16;
                2: extra_shb_step = 18;
                default: extra_shb_step = -1;
            endcase
            for (int s = 0; s <= 56; s++) begin
                if (s == rst_s) pulse_reset();
                run_range(s, s, ws_s, ws_c, hm_s, hm_c);
            end
        end
        extra_shb_step = -1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tia_horizontal_decode.md
# tia_horizontal_decode

Single-clock horizontal timing decoder. It sits directly downstream of the horizontal LFSR counter. It consumes the 6-bit LFSR count and the start-of-horizontal-blank pulse, and produces the line-level timing signals: HSYNC, HBLANK, colour burst, centre pulse, the WSYNC-driven CPU ready line and the HMOVE late-blank latch. It is a register-level replacement for the set/reset latch decode in the TIA horizontal sync section.

## Interface
Parameters: none. Decode patterns are fixed constants.

Ports:
- `clk` input 1: colour clock; all state changes on its rising edge.
- `resl` input 1: reset, synchronous, active-low.
- `hphi_en` input 1: one-`clk` strobe, once per LFSR step (every 4 `clk`). `hcount` and `shb` are sampled only when this is high.
- `hcount` input 6: horizontal LFSR count, bits [5:0].
- `shb` input 1: start-horizontal-blank from the LFSR stage, high for one LFSR step at line wrap.
- `wsync_strobe` input 1: one-`clk` pulse on a CPU write to WSYNC.
- `hmove_strobe` input 1: one-`clk` pulse on a CPU write to HMOVE.
- `hsync` output 1: horizontal sync.
- `hblank` output 1: horizontal blank.
- `cburst` output 1: colour-burst window.
- `cnt` output 1: one-`clk` pulse at the line centre.
- `rdy` output 1: CPU ready; low while WSYNC is pending.
- `hmove_late` output 1: HMOVE latch state.

## Operation
- A decode event fires on a `clk` where `hphi_en`=1 and `hcount` matches a pattern (binary, bit 5 first):
  - SHS 111100: set `hsync`.
  - RHS 110111: clear `hsync`, set `cburst`.
  - RCB 001111: clear `cburst`.
  - RHB 011100: clear `hblank` if `hmove_late`=0.
  - LRHB 010111: clear `hblank` if `hmove_late`=1; clear `hmove_late`.
  - CNT 101100: pulse `cnt`.
- SHB event (`hphi_en`=1 and `shb`=1):
  - Set `hblank`.
  - Set `rdy`.
  - Leaves `hsync`, `cburst` and `hmove_late` unchanged.
- Error count 111111, the wrap value 010100, and all other counts decode nothing.
- `wsync_strobe` clears `rdy`, independent of `hphi_en`.
- `hmove_strobe` sets `hmove_late`, independent of `hphi_en`.
- Simultaneous events:
  - `wsync_strobe` on an SHB-event `clk`: the clear wins, so `rdy` goes 0 and waits a full line.
  - `hmove_strobe` on an RHB-event `clk`: the latch is treated as already set, so RHB is ignored and `hblank` ends at LRHB.
  - `hmove_strobe` on an LRHB-event `clk`: the set wins, `hmove_late` stays 1, and it is consumed at the next line's LRHB.
- With a correct LFSR stream, SHB and the decode events are mutually exclusive. If `shb` and an `hcount` match coincide anyway, SHB set actions apply after the decode actions (SHB wins).
- Reset mid-line forces reset values on the next edge. The decoder then resynchronises on the following decode events, with no memory of the previous line.

## Timing
- Reset values: `hsync`=0, `hblank`=1, `cburst`=0, `cnt`=0, `rdy`=1, `hmove_late`=0.
- All outputs are registered. Latency is one `clk` from the sampling edge to the output change.
- `cnt` is high for exactly one `clk` per line.
- `rdy`:
  - Falls on the `clk` after `wsync_strobe`.
  - Rises on the `clk` after the SHB event.
  - Minimum low time is 1 `clk` if the strobe arrives just before SHB.
- Nominal line, in LFSR steps from SHB at step 0:
  - `hsync` high for steps 4–8.
  - `cburst` high for steps 8–12.
  - `hblank` high for steps 0–16, or 0–18 with HMOVE.
  - `cnt` at step 36.
  - Wrap at step 56.
- Steps count as 4 `clk` each; edges appear 1 `clk` after the qualifying `hphi_en`.

## Configuration
- Macro `TIA_HMOVE_EN`.
- Defined:
  - The HMOVE latch exists and behaves as in Operation.
  - RHB/LRHB selection is live.
- Undefined:
  - `hmove_strobe` is ignored.
  - `hmove_late` is tied to 0.
  - `hblank` always clears at RHB.
  - LRHB decodes nothing.

## Test plan
- Reset with `resl`=0 for 2 `clk`, then run a full 57-step LFSR sequence → reset values hold until the first event. `hsync` rises 1 `clk` after step 4 and falls after step 8. `cburst` is high over steps 8–12. `hblank` falls after step 16. `cnt` is a single pulse after step 36.
- `wsync_strobe` at step 20 → `rdy`=0 from the next `clk`, stays 0 through step 56, and returns to 1 one `clk` after the SHB event.
- `wsync_strobe` coincident with the SHB event → `rdy` goes 0 and stays 0 for the whole next line (57 steps).
- With `TIA_HMOVE_EN`:
  - `hmove_strobe` at step 2 → `hblank` falls after step 18, not 16. `hmove_late` clears after step 18.
  - The next line without a strobe → `hblank` falls after step 16.
- With `TIA_HMOVE_EN`: `hmove_strobe` at step 30 → the current line is unaffected. The next line's `hblank` ends at step 18.
- Without `TIA_HMOVE_EN`: `hmove_strobe` at step 2 → `hblank` falls after step 16 and `hmove_late` stays 0.
- `resl` low at step 6 (`hsync`=1) → all outputs at reset values on the next `clk`. After release, the next SHS sets `hsync` normally. Count 111111 held for 10 steps decodes nothing.
